find_prime: RTL and testbench
=============================

Name: find_prime

Overview:
- Consumer end of the level-adjust → find-prime handshake.
- Samples the reduced candidate on `primeNumberInput` when `findPrimeEnable` rises.
- Searches upward for the smallest prime ≥ candidate, using sequential trial division by repeated subtraction. No divider and no `%` operator.
- Presents the prime with a one-cycle `primeValid` pulse to the game/compare logic.

Parameters:
- WIDTH, 7, bit width of the candidate, result, divisor and remainder.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- findPrimeEnable  input  1  request level from the level-adjust block; the request is its 0→1 edge.
- primeNumberInput  input  WIDTH  reduced candidate; valid in the cycle `findPrimeEnable` is first seen high.
- primeNumberOutput  output  WIDTH  last prime found; held until the next result.
- primeValid  output  1  one-cycle pulse when `primeNumberOutput` updates.
- busy  output  1  high from the capture cycle until the DONE cycle, inclusive.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE.
  - `primeNumberOutput`=0, `primeValid`=0, `busy`=0.
  - Internal cand/div/rem cleared; edge-detect register `enPrev` cleared to 0.
- Start condition:
  - `start` = `findPrimeEnable` & ~`enPrev`, where `enPrev` is registered every cycle.
  - Upstream holds enable high for several cycles; only the rising edge starts a search.
  - `start` is ignored unless state is IDLE; a rising edge while busy is dropped, not queued.
- Registers: `cand`, `div`, `rem`, each WIDTH bits. The squared-divisor compare is done in 2*WIDTH bits.
- IDLE:
  - On `start`: `cand` ← `primeNumberInput`, or 2 if the input is < 2.
  - `div` ← 2, `busy` ← 1, go to TEST.
- TEST:
  - If `div`*`div` > `cand`: `cand` is prime, go to DONE.
  - Else `rem` ← `cand`, go to SUB.
- SUB, one subtraction per cycle:
  - If `rem` ≥ `div`: `rem` ← `rem` − `div`, stay in SUB.
  - Else if `rem` == 0 (composite): go to NEXT.
  - Else (not a factor): `div` ← `div`+1, go to TEST.
- NEXT:
  - If `cand` == 2^WIDTH−1: `cand` ← 2 (wrap; unreachable for WIDTH=7 since 127 is prime, but required for other widths).
  - Else `cand` ← `cand`+1.
  - In both cases `div` ← 2, go to TEST.
- DONE, exactly one cycle:
  - `primeNumberOutput` ← `cand`, `primeValid` ← 1, `busy` ← 0 at the end of the cycle, go to IDLE.
  - `primeValid` is 0 in every other state.
- Latency:
  - Candidate 2 or 3: 3 cycles from the start edge to the `primeValid` cycle (IDLE→TEST→DONE, output registered).
  - General case: data-dependent, bounded by the trial-division loop.
  - Bench timeout: 4096 cycles for WIDTH=7.
- `findPrimeEnable` dropping mid-search does not abort the search.
- Reset mid-search: immediate return to IDLE with all outputs zero and no `primeValid` pulse. If enable is still high after reset release, that counts as a new rising edge because `enPrev` was reset.
- A rising edge arriving in the DONE cycle is ignored. A rising edge in the cycle after DONE (state IDLE) is accepted.

Optional Feature:
- CYCLE_COUNT_EN defined:
  - Adds output `searchCycles` [15:0], cleared on reset.
  - An internal counter clears on an accepted `start` and increments every cycle while `busy`, saturating at 16'hFFFF.
  - It is copied to `searchCycles` in the DONE cycle, alongside `primeNumberOutput`.
- CYCLE_COUNT_EN undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Input 0, enable pulsed → `primeNumberOutput`=2 with a single `primeValid`; same for input 1 → 2 and input 2 → 2, each within 3 cycles.
- Input 24 → 29; input 90 → 97; input 97 → 97; input 127 → 127; each with exactly one `primeValid` pulse and `busy` low afterwards.
- Enable held high 200 cycles with input 24 → exactly one `primeValid`; output stays 29 after the pulse.
- Second rising edge (input 50) while busy on input 90 → only result 97 appears; no later search for 50 starts.
- rst asserted mid-search on 90 → outputs 0 immediately, no `primeValid`. Release with enable still high and input 10 → result 11.
- With CYCLE_COUNT_EN defined: input 2 → `searchCycles`=2; input 24 → `searchCycles` matches the bench model's count; with CYCLE_COUNT_EN undefined the same vectors produce the same primes.

Source files
------------

// File: rtl/find_prime_if.sv
/******************************************************************************
 * Module   : find_prime_if
 * Purpose  : Handshake bundle between the level-adjust block and find_prime.
 *            Optional searchCycles member when CYCLE_COUNT_EN is defined.
 * Revision : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

interface find_prime_if #(
  parameter int WIDTH = 7
);
  logic             findPrimeEnable;
  logic [WIDTH-1:0] primeNumberInput;
  logic [WIDTH-1:0] primeNumberOutput;
  logic             primeValid;
  logic             busy;
`ifdef CYCLE_COUNT_EN
  logic [15:0]      searchCycles;

  modport master (
    output findPrimeEnable, primeNumberInput,
    input  primeNumberOutput, primeValid, busy, searchCycles
  );
  modport slave (
    input  findPrimeEnable, primeNumberInput,
    output primeNumberOutput, primeValid, busy, searchCycles
  );
`else
  modport master (
    output findPrimeEnable, primeNumberInput,
    input  primeNumberOutput, primeValid, busy
  );
  modport slave (
    input  findPrimeEnable, primeNumberInput,
    output primeNumberOutput, primeValid, busy
  );
`endif
endinterface

`default_nettype wire

// File: rtl/find_prime.sv
/******************************************************************************
 * Module   : find_prime
 * Purpose  : Finds the smallest prime >= a sampled candidate by trial division
 *            with repeated subtraction. Optional macro: CYCLE_COUNT_EN.
 * Revision : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

module find_prime #(
  parameter int WIDTH = 7
) (
  input  logic         clk,
  input  logic         rst,
  find_prime_if.slave  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TEST = 3'd1;
  localparam logic [2:0] S_SUB  = 3'd2;
  localparam logic [2:0] S_NEXT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] CAND_MAX = {WIDTH{1'b1}};

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             en_prev_q;

  logic             start;
  logic [2*WIDTH-1:0] div_sq;
  logic [2*WIDTH-1:0] cand_ext;

  assign start    = bus.findPrimeEnable & ~en_prev_q;
  assign div_sq   = {{WIDTH{1'b0}}, div_q} * {{WIDTH{1'b0}}, div_q};
  assign cand_ext = {{WIDTH{1'b0}}, cand_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cand_q    <= '0;
      div_q     <= '0;
      rem_q     <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      en_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      div_q     <= div_d;
      rem_q     <= rem_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      en_prev_q <= bus.findPrimeEnable;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    div_d   = div_q;
    rem_d   = rem_q;
    out_d   = out_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cand_d  = (bus.primeNumberInput < TWO) ? TWO : bus.primeNumberInput;
          div_d   = TWO;
          busy_d  = 1'b1;
          state_d = S_TEST;
        end
      end
      S_TEST: begin
        // No divisor up to sqrt(cand) divided it, so cand is prime.
        if (div_sq > cand_ext) begin
          state_d = S_DONE;
        end else begin
          rem_d   = cand_q;
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        if (rem_q >= div_q) begin
          rem_d = rem_q - div_q;
        end else if (rem_q == '0) begin
          state_d = S_NEXT;
        end else begin
          div_d   = div_q + ONE;
          state_d = S_TEST;
        end
      end
      S_NEXT: begin
        cand_d  = (cand_q == CAND_MAX) ? TWO : cand_q + ONE;
        div_d   = TWO;
        state_d = S_TEST;
      end
      S_DONE: begin
        out_d   = cand_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef CYCLE_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cyc_q, cyc_d;
  logic [15:0] cnt_inc;

  // Saturating count of busy cycles; the DONE cycle itself is included.
  assign cnt_inc = (cnt_q == 16'hFFFF) ? 16'hFFFF : cnt_q + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      cyc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      cyc_q <= cyc_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    cyc_d = cyc_q;
    if (state_q == S_IDLE && start) begin
      cnt_d = '0;
    end else if (busy_q) begin
      cnt_d = cnt_inc;
    end
    if (state_q == S_DONE) begin
      cyc_d = cnt_inc;
    end
  end

  always_comb begin
    bus.searchCycles = cyc_q;
  end
`endif

  always_comb begin
    bus.primeNumberOutput = out_q;
    bus.primeValid        = valid_q;
    bus.busy              = busy_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_find_prime.sv
/******************************************************************************
 * Module   : tb_find_prime
 * Purpose  : Directed self-checking bench for find_prime (honours CYCLE_COUNT_EN).
 * Revision : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

module tb_find_prime;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  find_prime_if #(.WIDTH(7)) u_if ();

  find_prime #(.WIDTH(7)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

`ifdef CYCLE_COUNT_EN
  // Busy cycles (TEST/SUB/NEXT visits plus DONE) for a given start value.
  function automatic int model_cycles(input int c);
    int cand;
    int d;
    int r;
    int n;
    cand = (c < 2) ? 2 : c;
    d = 2;
    n = 0;
    while (1) begin
      n++;
      if (d * d > cand) return n + 1;
      r = cand;
      while (1) begin
        n++;
        if (r >= d) begin
          r = r - d;
        end else if (r == 0) begin
          n++;
          cand = (cand == 127) ? 2 : cand + 1;
          d = 2;
          break;
        end else begin
          d++;
          break;
        end
      end
    end
  endfunction
`endif

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!u_if.primeValid && lat < 4096) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_search(input string tag, input int cand, input int exp, input bit chk_lat);
    int lat;
    int pulses;
    u_if.primeNumberInput = 7'(cand);
    u_if.findPrimeEnable  = 1'b1;
    wait_valid(lat);
    check({tag, "_valid"}, 32'(u_if.primeValid), 32'd1);
    check({tag, "_out"}, 32'(u_if.primeNumberOutput), 32'(exp));
    if (chk_lat) check({tag, "_lat"}, 32'(lat), 32'd3);
`ifdef CYCLE_COUNT_EN
    check({tag, "_cyc"}, 32'(u_if.searchCycles), 32'(model_cycles(cand)));
`endif
    pulses = u_if.primeValid ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      pulses += u_if.primeValid ? 1 : 0;
    end
    check({tag, "_pulses"}, 32'(pulses), 32'd1);
    check({tag, "_busy"}, 32'(u_if.busy), 32'd0);
    check({tag, "_hold"}, 32'(u_if.primeNumberOutput), 32'(exp));
    u_if.findPrimeEnable = 1'b0;
    tick();
  endtask

  initial begin
    int pulses;
    int lat;
    int busy_seen;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    u_if.findPrimeEnable  = 1'b0;
    u_if.primeNumberInput = '0;
    tick();
    tick();
    check("rst_out", 32'(u_if.primeNumberOutput), 32'd0);
    check("rst_valid", 32'(u_if.primeValid), 32'd0);
    check("rst_busy", 32'(u_if.busy), 32'd0);
`ifdef CYCLE_COUNT_EN
    check("rst_cyc", 32'(u_if.searchCycles), 32'd0);
`endif
    rst = 1'b0;
    tick();

    run_search("in0", 0, 2, 1'b1);
    run_search("in1", 1, 2, 1'b1);
    run_search("in2", 2, 2, 1'b1);
    run_search("in24", 24, 29, 1'b0);
    run_search("in90", 90, 97, 1'b0);
    run_search("in97", 97, 97, 1'b0);
    run_search("in127", 127, 127, 1'b0);

    // Enable held high for a long time: only its rising edge counts.
    u_if.primeNumberInput = 7'd24;
    u_if.findPrimeEnable  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      pulses += u_if.primeValid ? 1 : 0;
    end
    check("hold_pulses", 32'(pulses), 32'd1);
    check("hold_out", 32'(u_if.primeNumberOutput), 32'd29);
    u_if.findPrimeEnable = 1'b0;
    tick();

    // A second rising edge during a search is dropped.
    u_if.primeNumberInput = 7'd90;
    u_if.findPrimeEnable  = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    u_if.findPrimeEnable = 1'b0;
    tick();
    u_if.primeNumberInput = 7'd50;
    u_if.findPrimeEnable  = 1'b1;
    tick();
    wait_valid(lat);
    check("drop_out", 32'(u_if.primeNumberOutput), 32'd97);
    pulses = 0;
    busy_seen = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      pulses += u_if.primeValid ? 1 : 0;
      busy_seen += u_if.busy ? 1 : 0;
    end
    check("drop_pulses", 32'(pulses), 32'd0);
    check("drop_busy", 32'(busy_seen), 32'd0);
    check("drop_hold", 32'(u_if.primeNumberOutput), 32'd97);
    u_if.findPrimeEnable = 1'b0;
    tick();

    // Asynchronous reset mid-search, enable still high on release.
    u_if.primeNumberInput = 7'd90;
    u_if.findPrimeEnable  = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("mid_busy_pre", 32'(u_if.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_out", 32'(u_if.primeNumberOutput), 32'd0);
    check("mid_valid", 32'(u_if.primeValid), 32'd0);
    check("mid_busy", 32'(u_if.busy), 32'd0);
`ifdef CYCLE_COUNT_EN
    check("mid_cyc", 32'(u_if.searchCycles), 32'd0);
`endif
    u_if.primeNumberInput = 7'd10;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += u_if.primeValid ? 1 : 0;
    end
    check("mid_rst_pulses", 32'(pulses), 32'd0);
    rst = 1'b0;
    wait_valid(lat);
    check("mid_restart_valid", 32'(u_if.primeValid), 32'd1);
    check("mid_restart_out", 32'(u_if.primeNumberOutput), 32'd11);
    u_if.findPrimeEnable = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
